// File: rtl/mux_arb_pkg.sv
// Shared constants and FSM state encoding for the mux select arbiter.
package mux_arb_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;
endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request searching last+1, last+2, ... (mod N_CH).
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    any   = |req;
    // Index arithmetic wraps naturally in SEL_W bits, so last itself is searched last.
    for (int k = 1; k <= N_CH; k++) begin
      cand = last + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select, with bounded hold time and
// an optional dead gap between owners. All outputs are registered.
module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  output logic [SEL_W-1:0] select,
  output logic             sel_valid,
  output logic [N_CH-1:0]  grant,
  output logic             preempt
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [N_CH-1:0] ONE     = N_CH'(1);

  state_e           state_q;
  logic [HW-1:0]    hold_q;
  logic [GW-1:0]    gap_q;
  logic [SEL_W-1:0] last_q;

  logic [SEL_W-1:0] pick_idx, pick_last;
  logic             pick_any;
  logic             rel_norm, rel_forced;

  // In GRANT the current owner is the pointer, so a back-to-back handover
  // already treats the releasing owner as lowest priority.
  assign pick_last  = (state_q == GRANT) ? select : last_q;
  assign rel_norm   = !req[select];
  assign rel_forced = (hold_q == HOLD_LAST) && |(req & ~grant);

  rr_pick u_pick (
    .req  (req),
    .last (pick_last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      select    <= '0;
      sel_valid <= 1'b0;
      grant     <= '0;
      preempt   <= 1'b0;
      hold_q    <= '0;
      gap_q     <= '0;
      last_q    <= SEL_W'(N_CH - 1);
    end else begin
      preempt <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q   <= GRANT;
            select    <= pick_idx;
            sel_valid <= 1'b1;
            grant     <= ONE << pick_idx;
            hold_q    <= '0;
          end
        end
        GRANT: begin
          if (rel_norm || rel_forced) begin
            last_q  <= select;
            hold_q  <= '0;
            preempt <= rel_forced && !rel_norm;
            if (GAP_CYCLES == 0) begin
              if (pick_any) begin
                select <= pick_idx;
                grant  <= ONE << pick_idx;
              end else begin
                state_q   <= IDLE;
                sel_valid <= 1'b0;
                grant     <= '0;
              end
            end else begin
              state_q   <= GAP;
              gap_q     <= '0;
              sel_valid <= 1'b0;
              grant     <= '0;
            end
          end else if (hold_q != HOLD_MAX) begin
            hold_q <= hold_q + HW'(1);
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) state_q <= IDLE;
          else                   gap_q   <= gap_q + GW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scoreboard bench: dut0 uses GAP_CYCLES=1, dut1 uses GAP_CYCLES=0; a random phase checks invariants.
module tb_mux_select_arbiter;
  localparam int MH = 8;
  localparam int GA = 1;

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic       p;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rs  [2];
  logic [3:0] rq  [2];
  logic [1:0] sel [2];
  logic       sv  [2];
  logic [3:0] gr  [2];
  logic       pr  [2];

  exp_t qa[$];
  exp_t qb[$];
  exp_t e;
  int   nvec = 0;
  int   nerr = 0;
  bit   rnd  = 0;
  int   wt[2][4];
  logic [3:0] rq_prev[2];

  mux_select_arbiter #(.MAX_HOLD(MH), .GAP_CYCLES(GA)) dut0 (
    .clk(clk), .rst(rs[0]), .req(rq[0]), .select(sel[0]),
    .sel_valid(sv[0]), .grant(gr[0]), .preempt(pr[0]));

  mux_select_arbiter #(.MAX_HOLD(MH), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst(rs[1]), .req(rq[1]), .select(sel[1]),
    .sel_valid(sv[1]), .grant(gr[1]), .preempt(pr[1]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, want finish");
    $fatal(1);
  end

  // exp describes outputs visible in the cycle just entered; r/rst_v drive the next edge.
  task automatic step(input int d, input logic rst_v, input logic [3:0] r,
                      input logic v, input logic [1:0] s, input logic p, input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    x.v = v; x.s = s; x.p = p; x.tag = tag;
    if (d == 0) qa.push_back(x);
    else        qb.push_back(x);
    rs[d] = rst_v;
    rq[d] = r;
  endtask

  task automatic seq_a();
    int ow[5] = '{0, 1, 2, 3, 0};
    logic [3:0] nr;
    rs[0] = 1; rq[0] = 4'b0000;
    repeat (2) @(posedge clk);
    step(0, 0, 4'b1111, 0, 2'd0, 0, "reset_state");
    // all four requesting: 8 valid, preempt gap cycle, idle cycle, next owner
    for (int o = 0; o < 5; o++)
      for (int c = 0; c < 10; c++) begin
        nr = (o == 4 && c == 9) ? 4'b0100 : 4'b1111;
        if (c < 8)       step(0, 0, nr, 1, 2'(ow[o]), 0, "rr_valid");
        else if (c == 8) step(0, 0, nr, 0, 2'(ow[o]), 1, "rr_preempt");
        else             step(0, 0, nr, 0, 2'(ow[o]), 0, "rr_idle");
      end
    for (int c = 0; c < 20; c++)
      step(0, 0, (c == 19) ? 4'b0000 : 4'b0100, 1, 2'd2, 0, "lone_hold");
    step(0, 0, 4'b0010, 0, 2'd2, 0, "lone_gap");
    step(0, 0, 4'b0010, 0, 2'd2, 0, "lone_idle");
    step(0, 0, 4'b1010, 1, 2'd1, 0, "drop_own1");
    step(0, 0, 4'b1010, 1, 2'd1, 0, "drop_own2");
    step(0, 0, 4'b1000, 1, 2'd1, 0, "drop_own3");
    step(0, 0, 4'b1000, 0, 2'd1, 0, "drop_gap");
    step(0, 0, 4'b1000, 0, 2'd1, 0, "drop_idle");
    step(0, 0, 4'b1000, 1, 2'd3, 0, "drop_next");
    step(0, 0, 4'b0100, 1, 2'd3, 0, "drop_next2");
    step(0, 0, 4'b0100, 0, 2'd3, 0, "ch3_gap");
    step(0, 0, 4'b0100, 0, 2'd3, 0, "ch3_idle");
    step(0, 0, 4'b0100, 1, 2'd2, 0, "ch2_grant");
    step(0, 1, 4'b0100, 1, 2'd2, 0, "ch2_grant2");
    step(0, 0, 4'b0101, 0, 2'd0, 0, "mid_reset");
    step(0, 0, 4'b0101, 1, 2'd0, 0, "post_reset");
    step(0, 0, 4'b0000, 1, 2'd0, 0, "post_reset2");
    step(0, 0, 4'b0000, 0, 2'd0, 0, "end_gap");
    step(0, 0, 4'b0000, 0, 2'd0, 0, "end_idle");
  endtask

  task automatic seq_b();
    int ow[4] = '{0, 1, 0, 1};
    logic [3:0] nr;
    rs[1] = 1; rq[1] = 4'b0000;
    repeat (2) @(posedge clk);
    step(1, 0, 4'b0011, 0, 2'd0, 0, "b_reset_state");
    // back-to-back handover: valid never drops, preempt on the first cycle of each new owner
    for (int o = 0; o < 4; o++)
      for (int c = 0; c < 8; c++) begin
        nr = (o == 3 && c == 7) ? 4'b0000 : 4'b0011;
        step(1, 0, nr, 1, 2'(ow[o]), (o > 0 && c == 0), "b_alt");
      end
    step(1, 0, 4'b0000, 0, 2'd1, 0, "b_to_idle");
  endtask

  always @(negedge clk) begin
    logic [7:0] act, want;
    bit ok;
    int bnd;
    for (int d = 0; d < 2; d++) begin
      if ((d == 0 && qa.size() > 0) || (d == 1 && qb.size() > 0)) begin
        e = (d == 0) ? qa.pop_front() : qb.pop_front();
        act  = {sv[d], sel[d], gr[d], pr[d]};
        want = {e.v, e.s, (e.v ? (4'b0001 << e.s) : 4'b0000), e.p};
        nvec++;
        if (act !== want) begin
          nerr++;
          $display("FAIL %s dut%0d: got v=%b sel=%0d grant=%b pre=%b, want v=%b sel=%0d grant=%b pre=%b",
                   e.tag, d, sv[d], sel[d], gr[d], pr[d], e.v, e.s, want[4:1], e.p);
        end
      end
      if (rnd) begin
        bnd = (d == 0) ? 3 * (MH + GA + 1) + GA + 1 : 3 * (MH + 1) + 1;
        ok = (gr[d] === (sv[d] ? (4'b0001 << sel[d]) : 4'b0000));
        if (sv[d] && !rq_prev[d][sel[d]]) ok = 0;
        if (d == 0 && pr[d] && sv[d]) ok = 0;
        for (int i = 0; i < 4; i++) begin
          if (rq[d][i] && !gr[d][i]) wt[d][i]++;
          else                       wt[d][i] = 0;
          if (wt[d][i] > bnd) ok = 0;
        end
        nvec++;
        if (!ok) begin
          nerr++;
          $display("FAIL rand_inv dut%0d: got sel=%0d v=%b grant=%b pre=%b prevreq=%b wait=%0d/%0d/%0d/%0d, want onehot grant of a requester, wait<=%0d",
                   d, sel[d], sv[d], gr[d], pr[d], rq_prev[d], wt[d][0], wt[d][1], wt[d][2], wt[d][3], bnd);
        end
      end else begin
        for (int i = 0; i < 4; i++) wt[d][i] = 0;
      end
      rq_prev[d] = rq[d];
    end
  end

  initial begin
    logic [3:0] r;
    rs[0] = 1; rs[1] = 1; rq[0] = 0; rq[1] = 0;
    fork
      seq_a();
      seq_b();
    join
    @(posedge clk);
    #1;
    rnd = 1;
    r = 4'b0000;
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0) r[i] = ~r[i];
      rq[0] = r;
      rq[1] = r;
      @(posedge clk);
      #1;
    end
    rnd = 0;
    @(negedge clk);
    nvec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
